sha3_digest_squeezer: RTL and testbench
=======================================

Name: sha3_digest_squeezer

Overview:
- Reader end of the Keccak state datapath. Theta and the rest of the round logic write the 25-lane state; this block reads the digest lanes back out.
- After the permutation finishes, the core pulses a load and this block captures the low DIGEST_LANES lanes (lanes 0..3 for SHA3-256).
- It then streams the captured digest as WORD_W-bit words over a valid/ready handshake toward the AXI/PS-side output FIFO on the Arty Z7-20.

Parameters:
- DIGEST_LANES, 4, number of 64-bit lanes captured (legal 1..4).
- WORD_W, 32, output word width (legal 32 or 64).
- NUM_WORDS (localparam), DIGEST_LANES*64/WORD_W, words per digest.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_load  input  1  capture request from the permutation controller.
- in_digest  input  DIGEST_LANES*64  lanes packed; lane i = bits [64i+63:64i].
- in_ready  output  1  block idle and able to accept in_load.
- in_abort  input  1  synchronous flush of the current digest.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WORD_W  current digest word.
- out_last  output  1  current word is the final word of the digest.
- digest_cnt  output  16  count of fully delivered digests.

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - state=IDLE, word index=0, capture register=0.
  - out_valid=0, out_last=0, out_data=0, digest_cnt=0, in_ready=1.
- FSM states: IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_load=1 captures in_digest into the internal register, clears the word index, and moves to STREAM.
  - out_valid rises on the next cycle, so capture-to-first-word latency is 1 cycle.
- STREAM:
  - in_ready=0; in_load is ignored and the captured data is unaffected.
  - out_valid=1; out_data = capture[WORD_W*idx +: WORD_W]. Word 0 is the low half of lane 0 (Keccak little-endian order).
  - A transfer occurs when out_valid & out_ready. Then idx increments.
  - out_data, out_last and idx stay stable while out_ready=0.
  - out_last = (idx == NUM_WORDS-1).
  - A transfer with out_last=1 returns the FSM to IDLE and increments digest_cnt, which wraps 16'hFFFF to 0.
  - in_ready returns 1 on the cycle after the final transfer, giving one bubble between digests.
- in_abort (synchronous, highest priority over all other inputs):
  - Forces IDLE next cycle with out_valid=0 and idx=0.
  - digest_cnt does not increment.
  - In IDLE, abort together with in_load means the load is discarded.
- out_ready while out_valid=0 has no effect.
- The word index is $clog2(NUM_WORDS) bits wide, or 1 bit when NUM_WORDS=1. It never exceeds NUM_WORDS-1.
- All outputs are registered except in_ready and out_last, which are decoded from state and idx.

Optional Feature:
- SQUEEZE_BYTE_SWAP_EN defined:
  - Each out_data word is byte-reversed (byte 0 goes to MSB), giving the conventional hex-string order for PS readout.
  - Word ordering and the handshake are unchanged.
- Not defined: out_data is the raw little-endian slice and no swap logic is present.

Test Plan:
- Basic SHA3-256 digest:
  - Stimulus: reset, then in_load with lane0=64'h66d71ebff8c6ffa7 (SHA3-256 of the empty string), out_ready=1.
  - Response: words 32'hf8c6ffa7, then 32'h66d71ebf, …; 8 words total; out_last only on word 7; digest_cnt=1; in_ready=1 one cycle after the last transfer.
- Backpressure:
  - Stimulus: same load, out_ready toggling 1,0,0,1.
  - Response: out_data/out_last held constant during stalls; no word duplicated or dropped; exactly 8 transfers.
- Load while busy:
  - Stimulus: second in_load with lane0=64'h0 pulsed during STREAM.
  - Response: ignored; the remaining words still come from the first capture; digest_cnt ends at 1.
- Abort:
  - Stimulus: in_abort after word 3.
  - Response: out_valid=0 next cycle; digest_cnt unchanged. A new load with lane0=64'h0706050403020100 then yields word 0 = 32'h03020100.
- Async reset mid-stream:
  - Stimulus: rst_n low between clock edges during word 5.
  - Response: out_valid, out_last, digest_cnt go to 0 immediately; in_ready=1 after release.
- SQUEEZE_BYTE_SWAP_EN build:
  - Stimulus: empty-string digest as in the first scenario.
  - Response: first word 32'ha7ffc6f8, second 32'hbf1ed766.

Source files
------------

// File: rtl/sha3_digest_squeezer.sv
// sha3_digest_squeezer: captures the low DIGEST_LANES Keccak lanes when the
// permutation controller pulses in_load, then streams them as WORD_W-bit
// words (word 0 = low half of lane 0) over a valid/ready handshake.
// Optional build macro: SQUEEZE_BYTE_SWAP_EN byte-reverses every output word
// so the PS side reads the digest in conventional hex-string order.
`timescale 1ns/1ps
module sha3_digest_squeezer #(
  parameter int DIGEST_LANES = 4,
  parameter int WORD_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_load,
  input  logic [DIGEST_LANES*64-1:0]   in_digest,
  output logic                         in_ready,
  input  logic                         in_abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_last,
  output logic [15:0]                  digest_cnt
);

  localparam int NUM_WORDS = DIGEST_LANES * 64 / WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    capture_q, capture_d;
  logic                                valid_q, valid_d;
  logic [WORD_W-1:0]                   data_q, data_d;
  logic [15:0]                         cnt_q, cnt_d;

  // Presentation of one captured word on out_data (raw or byte-reversed).
  function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
`ifdef SQUEEZE_BYTE_SWAP_EN
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    end
    return r;
`else
    return w;
`endif
  endfunction

  // Next-state, capture, word index and registered-output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture_d = capture_q;
    valid_d   = valid_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    if (in_abort) begin
      // Flush wins over load and transfer; the digest is not counted.
      state_d = ST_IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_load) begin
            capture_d = in_digest;
            idx_d     = '0;
            state_d   = ST_STREAM;
            valid_d   = 1'b1;
            data_d    = fmt_word(in_digest[WORD_W-1:0]);
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              valid_d = 1'b0;
              data_d  = '0;
              cnt_d   = cnt_q + 16'd1;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              valid_d = 1'b1;
              data_d  = fmt_word(capture_q[idx_d]);
            end
          end else begin
            // Stall: word, index and capture are held.
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          data_d  = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      capture_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      capture_q <= capture_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_last   = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign digest_cnt = cnt_q;

endmodule

// File: tb/tb_sha3_digest_squeezer.sv
// Scoreboard bench for sha3_digest_squeezer: stimulus pushes the expected
// words of each loaded digest; a negedge monitor compares every presented word.
`timescale 1ns/1ps
module tb_sha3_digest_squeezer;

  logic         clk;
  logic         rst_n;
  logic         in_load;
  logic [255:0] in_digest;
  logic         in_ready;
  logic         in_abort;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [15:0]  digest_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_w;
  logic [31:0] tbl_a[8];
  logic [31:0] tbl_b[8];

  // Empty-string SHA3-256 digest, lanes 3..0.
  localparam logic [255:0] DIG_A = {64'h4a43f8804b0ad882, 64'hfa493be44dff80f5,
                                    64'h62d661a05647c151, 64'h66d71ebff8c6ffa7};
  // Incrementing byte pattern 0x00..0x1f.
  localparam logic [255:0] DIG_B = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                                    64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

  sha3_digest_squeezer #(.DIGEST_LANES(4), .WORD_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_load    (in_load),
    .in_digest  (in_digest),
    .in_ready   (in_ready),
    .in_abort   (in_abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .digest_cnt (digest_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [255:0] d, input bit use_b);
    in_load   = 1'b1;
    in_digest = d;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, use_b ? tbl_b[i] : tbl_a[i]});
    end
    step();
    in_load = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = in_ready && !out_valid && (exp_q.size() == 0);
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  // Monitor: compare each presented word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_w = exp_q[0];
        check("word_data", {32'd0, out_data}, {32'd0, exp_w[31:0]});
        check("word_last", {63'd0, out_last}, {63'd0, exp_w[32]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int  xfer0;
    bit  done;
`ifdef SQUEEZE_BYTE_SWAP_EN
    tbl_a = '{32'ha7ffc6f8, 32'hbf1ed766, 32'h51c14756, 32'ha061d662,
              32'hf580ff4d, 32'he43b49fa, 32'h82d80a4b, 32'h80f8434a};
    tbl_b = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
              32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
`else
    tbl_a = '{32'hf8c6ffa7, 32'h66d71ebf, 32'h5647c151, 32'h62d661a0,
              32'h4dff80f5, 32'hfa493be4, 32'h4b0ad882, 32'h4a43f880};
    tbl_b = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
`endif
    rst_n = 1'b0; in_load = 1'b0; in_digest = '0; in_abort = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_last",  {63'd0, out_last},  64'd0);
    check("rst_data",  {32'd0, out_data},  64'd0);
    check("rst_cnt",   {48'd0, digest_cnt}, 64'd0);
    check("rst_ready", {63'd0, in_ready},  64'd1);
    #2 rst_n = 1'b1;
    step();

    // Basic digest, out_ready held high.
    out_ready = 1'b1;
    do_load(DIG_A, 1'b0);
    check("basic_first_valid", {63'd0, out_valid}, 64'd1);
    repeat (7) step();
    check("basic_last_flag", {63'd0, out_last}, 64'd1);
    check("basic_busy",      {63'd0, in_ready}, 64'd0);
    step();
    check("basic_ready_after", {63'd0, in_ready},   64'd1);
    check("basic_valid_after", {63'd0, out_valid},  64'd0);
    check("basic_cnt",         {48'd0, digest_cnt}, 64'd1);
    check("basic_q_empty",     exp_q.size(),        64'd0);

    // Backpressure with out_ready pattern 1,0,0,1.
    xfer0 = n_xfer;
    do_load(DIG_A, 1'b0);
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      step();
      done = in_ready && (exp_q.size() == 0);
    end
    check("bp_done",  {63'd0, done}, 64'd1);
    check("bp_xfers", n_xfer - xfer0, 64'd8);
    check("bp_cnt",   {48'd0, digest_cnt}, 64'd2);

    // Load while busy is ignored.
    out_ready = 1'b1;
    do_load(DIG_A, 1'b0);
    repeat (2) step();
    check("busy_ready", {63'd0, in_ready}, 64'd0);
    in_load = 1'b1; in_digest = '0;
    step();
    in_load = 1'b0;
    run_until_idle("busy_done", 20);
    check("busy_cnt", {48'd0, digest_cnt}, 64'd3);

    // Abort after word 3, then abort together with load in IDLE.
    do_load(DIG_A, 1'b0);
    repeat (4) step();
    out_ready = 1'b0;
    in_abort  = 1'b1;
    step();
    in_abort = 1'b0;
    exp_q.delete();
    check("abort_valid", {63'd0, out_valid},  64'd0);
    check("abort_ready", {63'd0, in_ready},   64'd1);
    check("abort_cnt",   {48'd0, digest_cnt}, 64'd3);
    in_abort = 1'b1; in_load = 1'b1; in_digest = DIG_B;
    step();
    in_abort = 1'b0; in_load = 1'b0;
    check("abort_load_valid", {63'd0, out_valid}, 64'd0);
    check("abort_load_ready", {63'd0, in_ready},  64'd1);
    out_ready = 1'b1;
    do_load(DIG_B, 1'b1);
    run_until_idle("after_abort_done", 20);
    check("after_abort_cnt", {48'd0, digest_cnt}, 64'd4);

    // Asynchronous reset during word 5.
    do_load(DIG_A, 1'b0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", {63'd0, out_valid},  64'd0);
    check("areset_last",  {63'd0, out_last},   64'd0);
    check("areset_cnt",   {48'd0, digest_cnt}, 64'd0);
    exp_q.delete();
    out_ready = 1'b0;
    #3 rst_n = 1'b1;
    step();
    check("areset_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    do_load(DIG_B, 1'b1);
    run_until_idle("recover_done", 20);
    check("recover_cnt", {48'd0, digest_cnt}, 64'd1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
